// File: rtl/stoptimer_pkg.sv
// Shared types and default sizing for the start/stop elapsed-cycle timer.
package stoptimer_pkg;
  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;
endpackage

// File: rtl/stoptimer_prescaler.sv
// Divides counting edges by PRESCALE; the phase persists while disabled.
module stoptimer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  // A 1-bit counter that stays at 0 covers PRESCALE=1 without a special case.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_tick    = i_en && w_at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/stoptimer.sv
// Start/stop stopwatch: counts (prescaled) cycles in RUN, holds in STOPPED,
// resumes without clearing, and flags a sticky overflow on wrap.
module stoptimer
  import stoptimer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] elapsed_time,
  output logic             running,
  output logic             overflow
);
  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             w_count_en;
  logic             w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // stop dominates start in both states.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOPPED: if (start && !stop) w_state_next = ST_RUN;
      ST_RUN:     if (stop)           w_state_next = ST_STOPPED;
      default:                        w_state_next = ST_STOPPED;
    endcase
  end

  // The edge that enters RUN does not count; the edge carrying stop does not either.
  assign w_count_en = (r_state == ST_RUN) && !stop;

  stoptimer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_count_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_tick) begin
      r_count <= r_count + 1'b1;
      if (&r_count) r_overflow <= 1'b1;
    end
  end

  assign elapsed_time = r_count;
  assign running      = (r_state == ST_RUN);
  assign overflow     = r_overflow;
endmodule

// File: tb/tb_stoptimer.sv
// Directed checks of the stopwatch: default instance plus a PRESCALE=4 instance.
module tb_stoptimer;
  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] elapsed_time;
  logic       running, overflow;
  logic       p_rst, p_start, p_stop;
  logic [7:0] p_elapsed_time;
  logic       p_running, p_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stoptimer #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .elapsed_time (elapsed_time),
    .running      (running),
    .overflow     (overflow)
  );

  stoptimer #(.WIDTH(8), .PRESCALE(4)) dut_p4 (
    .clk          (clk),
    .rst          (p_rst),
    .start        (p_start),
    .stop         (p_stop),
    .elapsed_time (p_elapsed_time),
    .running      (p_running),
    .overflow     (p_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    p_rst = 1'b1; p_start = 1'b0; p_stop = 1'b0;
    tick(1);
    check("rst_count", elapsed_time, 0);
    check("rst_run", running, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    start = 1'b1; tick(1); start = 1'b0;
    check("start_edge_count", elapsed_time, 0);
    check("start_edge_run", running, 1);
    tick(5);
    check("run5_count", elapsed_time, 5);

    stop = 1'b1; tick(1); stop = 1'b0;
    tick(3);
    check("stop_hold_count", elapsed_time, 5);
    check("stop_hold_run", running, 0);

    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    check("resume_count", elapsed_time, 9);
    check("resume_run", running, 1);

    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst_run_count", elapsed_time, 0);
    check("rst_run_run", running, 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    check("restart6_count", elapsed_time, 6);

    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_edge_count", elapsed_time, 6);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    check("both_stopped_run", running, 0);
    check("both_stopped_count", elapsed_time, 6);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    check("pre_both_count", elapsed_time, 8);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    check("both_run_run", running, 0);
    check("both_run_count", elapsed_time, 8);

    rst = 1'b1; tick(1); rst = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(255);
    check("wrap_pre_count", elapsed_time, 255);
    check("wrap_pre_ovf", overflow, 0);
    tick(1);
    check("wrap_count", elapsed_time, 0);
    check("wrap_ovf", overflow, 1);
    check("wrap_run", running, 1);
    tick(1);
    check("post_wrap_count", elapsed_time, 1);
    stop = 1'b1; tick(1); stop = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    check("ovf_sticky", overflow, 1);
    check("ovf_sticky_count", elapsed_time, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("ovf_clear", overflow, 0);

    p_rst = 1'b0;
    p_start = 1'b1; tick(1); p_start = 1'b0;
    check("p4_start_count", p_elapsed_time, 0);
    tick(3);
    check("p4_3edges", p_elapsed_time, 0);
    tick(9);
    check("p4_12edges", p_elapsed_time, 3);
    tick(2);
    p_stop = 1'b1; tick(1); p_stop = 1'b0;
    tick(3);
    check("p4_stopped_count", p_elapsed_time, 3);
    check("p4_stopped_run", p_running, 0);
    p_start = 1'b1; tick(1); p_start = 1'b0;
    tick(1);
    check("p4_phase_kept_a", p_elapsed_time, 3);
    tick(1);
    check("p4_phase_kept_b", p_elapsed_time, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
